// File: rtl/tag_maint_ctl.sv
// Purpose : tag RAM port arbiter plus maintenance sequencer (invalidate, clean, clean+invalidate sweeps).
// Latency : idle core accesses pass through combinationally; a sweep begins the cycle after the start request.
// Backpr. : the core is stalled for the whole sweep; each write-back holds the sweep until wb_ack is sampled.
//
// Ports:
//   nGCLK, nRESET            clock (all updates on posedge), asynchronous active-low reset
//   start_inv, start_clean   sweep requests, sampled only when idle; both together = clean+invalidate
//   core_rd_sel              core tag read line
//   core_wr_sel/_data/_ena   core tag write line, value and enable
//   tag_rd_data              tag RAM combinational read port
//   tag_rd_sel, tag_wr_*     tag RAM read select and write select/data/enable
//   wb_req, wb_addr, wb_ack  write-back handshake with the bus interface
//   busy, core_stall         sweep in progress (identical)
//   done                     one-cycle pulse in the final cycle of a sweep
module tag_maint_ctl #(
  parameter int NL  = 512,
  parameter int LSS = 9,
  parameter int LSH = LSS + 4,
  parameter int PSL = LSH + 1,
  parameter int TS  = 2 + (32 - PSL)
) (
  input  logic           nGCLK,
  input  logic           nRESET,
  input  logic           start_inv,
  input  logic           start_clean,
  input  logic [LSS-1:0] core_rd_sel,
  input  logic [LSS-1:0] core_wr_sel,
  input  logic [TS-1:0]  core_wr_data,
  input  logic           core_wr_ena,
  input  logic [TS-1:0]  tag_rd_data,
  input  logic           wb_ack,
  output logic [LSS-1:0] tag_rd_sel,
  output logic [LSS-1:0] tag_wr_sel,
  output logic [TS-1:0]  tag_wr_data,
  output logic           tag_wr_ena,
  output logic           wb_req,
  output logic [31:0]    wb_addr,
  output logic           busy,
  output logic           core_stall,
  output logic           done
);

  localparam int             PW       = TS - 2;
  localparam logic [LSS-1:0] LAST_IDX = LSS'(NL - 1);

  typedef struct packed {
    logic          v;
    logic          d;
    logic [PW-1:0] page;
  } tag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_READ,
    S_WB,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [LSS-1:0] idx_q, idx_d;
  logic           mode_clean_q, mode_clean_d;
  logic           mode_inv_q, mode_inv_d;
  logic [PW-1:0]  page_q, page_d;

  tag_t           rd_tag;
  logic           last_line;
  logic [LSS-1:0] idx_inc;

  assign rd_tag    = tag_t'(tag_rd_data);
  assign last_line = (idx_q == LAST_IDX);
  assign idx_inc   = idx_q + LSS'(1);

  // Only the page of the swept line needs to be kept: it forms the write-back
  // address and the cleaned tag; V/D are consumed in the READ cycle itself.
  assign wb_addr    = {page_q, idx_q, 5'b0};
  assign busy       = (state_q != S_IDLE);
  assign core_stall = busy;

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mode_clean_q <= 1'b0;
      mode_inv_q   <= 1'b0;
      page_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mode_clean_q <= mode_clean_d;
      mode_inv_q   <= mode_inv_d;
      page_q       <= page_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mode_clean_d = mode_clean_q;
    mode_inv_d   = mode_inv_q;
    page_d       = page_q;

    tag_rd_sel   = idx_q;
    tag_wr_sel   = idx_q;
    tag_wr_data  = '0;
    tag_wr_ena   = 1'b0;
    wb_req       = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Core owns the RAM; a core write coinciding with a start still lands.
        tag_rd_sel  = core_rd_sel;
        tag_wr_sel  = core_wr_sel;
        tag_wr_data = core_wr_data;
        tag_wr_ena  = core_wr_ena;
        if (start_inv || start_clean) begin
          mode_clean_d = start_clean;
          mode_inv_d   = start_inv;
          idx_d        = '0;
          state_d      = start_clean ? S_READ : S_INV;
        end
      end

      S_INV: begin
        // Invalidate-only needs no read: blind-write one line per cycle.
        tag_wr_ena = 1'b1;
        if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_inc;
        end
      end

      S_READ: begin
        page_d = rd_tag.page;
        if (rd_tag.v && rd_tag.d) begin
          state_d = S_WB;
        end else if (mode_inv_q) begin
          state_d = S_WRITE;
        end else if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_inc;
        end
      end

      S_WB: begin
        wb_req = 1'b1;
        if (wb_ack) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        tag_wr_ena  = 1'b1;
        // Clean keeps the line valid with D cleared; invalidate zeroes it.
        tag_wr_data = mode_inv_q ? '0 : {1'b1, 1'b0, page_q};
        if (last_line) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_inc;
          state_d = S_READ;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The bus side may take several cycles to accept; the address must not move meanwhile.
  a_wb_hold: assert property (@(posedge nGCLK) disable iff (!nRESET)
    (state_q == S_WB && !wb_ack) |=> (wb_req && $stable(wb_addr)));

  a_done_pulse: assert property (@(posedge nGCLK) disable iff (!nRESET)
    done |=> !done);

endmodule

// File: tb/tb_tag_maint_ctl.sv
module tb_tag_maint_ctl;

  localparam int NL  = 512;
  localparam int LSS = 9;
  localparam int TS  = 20;

  logic           nGCLK = 1'b0;
  logic           nRESET;
  logic           start_inv;
  logic           start_clean;
  logic [LSS-1:0] core_rd_sel;
  logic [LSS-1:0] core_wr_sel;
  logic [TS-1:0]  core_wr_data;
  logic           core_wr_ena;
  logic [TS-1:0]  tag_rd_data;
  logic           wb_ack;
  logic [LSS-1:0] tag_rd_sel;
  logic [LSS-1:0] tag_wr_sel;
  logic [TS-1:0]  tag_wr_data;
  logic           tag_wr_ena;
  logic           wb_req;
  logic [31:0]    wb_addr;
  logic           busy;
  logic           core_stall;
  logic           done;

  int n_vec = 0;
  int n_err = 0;

  always #5 nGCLK = ~nGCLK;

  tag_maint_ctl dut (
    .nGCLK        (nGCLK),
    .nRESET       (nRESET),
    .start_inv    (start_inv),
    .start_clean  (start_clean),
    .core_rd_sel  (core_rd_sel),
    .core_wr_sel  (core_wr_sel),
    .core_wr_data (core_wr_data),
    .core_wr_ena  (core_wr_ena),
    .tag_rd_data  (tag_rd_data),
    .wb_ack       (wb_ack),
    .tag_rd_sel   (tag_rd_sel),
    .tag_wr_sel   (tag_wr_sel),
    .tag_wr_data  (tag_wr_data),
    .tag_wr_ena   (tag_wr_ena),
    .wb_req       (wb_req),
    .wb_addr      (wb_addr),
    .busy         (busy),
    .core_stall   (core_stall),
    .done         (done)
  );

  // Tag RAM model: combinational read, posedge write, one-cycle bulk preload.
  logic [TS-1:0] ram [NL];
  logic          fill_go   = 1'b0;
  int            fill_kind = 0;

  assign tag_rd_data = ram[tag_rd_sel];

  // kind 0: all 0xFFFFF; 1: clean preload; 2: expected after clean; other: all zero
  function automatic logic [TS-1:0] pattern(input int kind, input int i);
    case (kind)
      0:       return 20'hFFFFF;
      1:       return (i == 3) ? 20'hC002A : (i == 7) ? 20'hFFFFF : (20'h80000 | 20'(i));
      2:       return (i == 3) ? 20'h8002A : (i == 7) ? 20'hBFFFF : (20'h80000 | 20'(i));
      default: return 20'h00000;
    endcase
  endfunction

  always @(posedge nGCLK) begin
    if (fill_go) begin
      for (int i = 0; i < NL; i++) ram[i[8:0]] <= pattern(fill_kind, i);
    end else if (tag_wr_ena) begin
      ram[tag_wr_sel] <= tag_wr_data;
    end
  end

  function automatic int ram_bad(input int kind);
    int n;
    n = 0;
    for (int i = 0; i < NL; i++) if (ram[i[8:0]] !== pattern(kind, i)) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    fill_kind = kind;
    fill_go   = 1'b1;
    @(posedge nGCLK); #1;
    fill_go   = 1'b0;
  endtask

  // Caller is one step past a posedge (cycle 0); returns in cycle 1.
  task automatic start_sweep(input logic inv, input logic cln);
    start_inv   = inv;
    start_clean = cln;
    @(posedge nGCLK); #1;
    start_inv   = 1'b0;
    start_clean = 1'b0;
  endtask

  // Sweep observer and BIU responder.
  logic [31:0] wb_addrs [$];
  int          wb_lens  [$];
  int          done_cnt, done_cyc, fall_cyc, addr_unstable;
  logic        stopped;

  task automatic run_sweep(input int ack_delay, input int inject_cyc,
                           input logic [31:0] stop_addr, input logic use_stop,
                           input int budget);
    int          age;
    logic [31:0] first_addr;
    bit          fin;
    age = 0; first_addr = '0; fin = 0;
    wb_addrs.delete(); wb_lens.delete();
    done_cnt = 0; done_cyc = 0; fall_cyc = 0; addr_unstable = 0; stopped = 1'b0;
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge nGCLK);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (use_stop && wb_req === 1'b1 && wb_addr === stop_addr) begin
        stopped = 1'b1;
        wb_ack  = 1'b0;
        fin     = 1;
      end else begin
        if (wb_req === 1'b1) begin
          if (age == 0) begin
            wb_addrs.push_back(wb_addr);
            first_addr = wb_addr;
          end else if (wb_addr !== first_addr) begin
            addr_unstable++;
          end
          wb_ack = (age == ack_delay);
          age++;
        end else begin
          if (age != 0) wb_lens.push_back(age);
          age    = 0;
          wb_ack = 1'b0;
        end
        if (c == inject_cyc) begin
          start_inv    = 1'b1;
          core_wr_ena  = 1'b1;
          core_wr_sel  = 9'd5;
          core_wr_data = 20'h5A5A5;
        end
        if (busy !== 1'b1) begin
          fall_cyc    = c;
          fin         = 1;
          start_inv   = 1'b0;
          core_wr_ena = 1'b0;
          wb_ack      = 1'b0;
        end
      end
    end
    if (!use_stop) begin
      @(posedge nGCLK); #1;
    end
  endtask

  function automatic logic [31:0] addr_at(input int k);
    return (wb_addrs.size() > k) ? wb_addrs[k] : 32'h0BAD0BAD;
  endfunction

  function automatic int len_at(input int k);
    return (wb_lens.size() > k) ? wb_lens[k] : -1;
  endfunction

  typedef struct {
    logic [8:0]  rd_sel;
    logic [8:0]  wr_sel;
    logic [19:0] wr_data;
    logic        wr_ena;
    logic        ack;
    logic [8:0]  e_rd_sel;
    logic [8:0]  e_wr_sel;
    logic [19:0] e_wr_data;
    logic        e_wr_ena;
    logic        e_wb_req;
    logic        e_busy;
  } vec_t;

  vec_t vt [5];
  int   bad;
  int   seen;

  initial begin
    vt[0] = '{9'h000, 9'h000, 20'h00000, 1'b0, 1'b0, 9'h000, 9'h000, 20'h00000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{9'h1FF, 9'h0AA, 20'hABCDE, 1'b1, 1'b0, 9'h1FF, 9'h0AA, 20'hABCDE, 1'b1, 1'b0, 1'b0};
    vt[2] = '{9'h155, 9'h1FF, 20'hFFFFF, 1'b0, 1'b1, 9'h155, 9'h1FF, 20'hFFFFF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{9'h003, 9'h007, 20'hC002A, 1'b1, 1'b1, 9'h003, 9'h007, 20'hC002A, 1'b1, 1'b0, 1'b0};
    vt[4] = '{9'h100, 9'h001, 20'h00001, 1'b1, 1'b0, 9'h100, 9'h001, 20'h00001, 1'b1, 1'b0, 1'b0};

    nRESET = 1'b0; start_inv = 1'b0; start_clean = 1'b0;
    core_rd_sel = '0; core_wr_sel = '0; core_wr_data = '0; core_wr_ena = 1'b0; wb_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge nGCLK);
    #1;
    check("rst_busy",   64'(busy),       64'd0);
    check("rst_stall",  64'(core_stall), 64'd0);
    check("rst_done",   64'(done),       64'd0);
    check("rst_wb_req", 64'(wb_req),     64'd0);
    check("rst_wr_ena", 64'(tag_wr_ena), 64'd0);
    check("rst_wb_addr", 64'(wb_addr),   64'd0);
    @(negedge nGCLK); nRESET = 1'b1;
    @(posedge nGCLK); #1;

    // Idle pass-through table
    for (int i = 0; i < 5; i++) begin
      core_rd_sel  = vt[i].rd_sel;
      core_wr_sel  = vt[i].wr_sel;
      core_wr_data = vt[i].wr_data;
      core_wr_ena  = vt[i].wr_ena;
      wb_ack       = vt[i].ack;
      @(negedge nGCLK);
      check($sformatf("idle_vec%0d", i),
            64'({tag_rd_sel, tag_wr_sel, tag_wr_data, tag_wr_ena, wb_req, busy}),
            64'({vt[i].e_rd_sel, vt[i].e_wr_sel, vt[i].e_wr_data, vt[i].e_wr_ena,
                 vt[i].e_wb_req, vt[i].e_busy}));
      @(posedge nGCLK); #1;
    end
    core_wr_ena = 1'b0; wb_ack = 1'b0;
    check("idle_wr_0aa", 64'(ram[9'h0AA]), 64'h00000ABCDE);
    check("idle_wr_001", 64'(ram[9'h001]), 64'h0000000001);

    // Invalidate-only: writes idx 0..511 in cycles 1..512, done 513, idle 514
    fill(0);
    start_inv = 1'b1;
    @(negedge nGCLK);
    check("inv_c0_busy", 64'(busy), 64'd0);
    @(posedge nGCLK); #1;
    start_inv = 1'b0;
    bad = 0; seen = 0;
    for (int c = 1; c <= NL; c++) begin
      @(negedge nGCLK);
      if (tag_wr_ena !== 1'b1 || tag_wr_sel !== 9'(c - 1) || tag_wr_data !== 20'h0 || busy !== 1'b1)
        bad++;
      if (wb_req !== 1'b0) seen++;
    end
    check("inv_seq_bad", 64'(bad), 64'd0);
    @(negedge nGCLK);
    check("inv_done_c513", 64'({done, busy, tag_wr_ena}), 64'b110);
    @(negedge nGCLK);
    check("inv_idle_c514", 64'({done, busy, core_stall}), 64'b000);
    @(posedge nGCLK); #1;
    check("inv_no_wb", 64'(seen), 64'd0);
    check("inv_ram_zero", 64'(ram_bad(3)), 64'd0);

    // Core write in the same cycle as start_inv lands, then the sweep zeroes it
    fill(0);
    start_inv = 1'b1; core_wr_ena = 1'b1; core_wr_sel = 9'd9; core_wr_data = 20'h12345;
    @(negedge nGCLK);
    check("cowr_pass", 64'({tag_wr_ena, tag_wr_sel, tag_wr_data}), 64'({1'b1, 9'd9, 20'h12345}));
    @(posedge nGCLK); #1;
    start_inv = 1'b0; core_wr_ena = 1'b0;
    check("cowr_ram9", 64'(ram[9'd9]), 64'h12345);
    run_sweep(0, 0, 32'h0, 1'b0, 700);
    check("cowr_done_cyc", 64'(done_cyc), 64'd513);
    check("cowr_ram_zero", 64'(ram_bad(3)), 64'd0);

    // Clean, ack two cycles after req: 510 clean lines x1 + 2 dirty x(1+3+1) = 520
    fill(1);
    start_sweep(1'b0, 1'b1);
    run_sweep(2, 0, 32'h0, 1'b0, 2000);
    check("cl_wb_count", 64'(wb_addrs.size()), 64'd2);
    check("cl_wb_addr0", 64'(addr_at(0)), 64'h000A8060);
    check("cl_wb_addr1", 64'(addr_at(1)), 64'hFFFFC0E0);
    check("cl_wb_len0", 64'(len_at(0)), 64'd3);
    check("cl_wb_len1", 64'(len_at(1)), 64'd3);
    check("cl_addr_stable", 64'(addr_unstable), 64'd0);
    check("cl_done_cnt", 64'(done_cnt), 64'd1);
    check("cl_done_cyc", 64'(done_cyc), 64'd521);
    check("cl_busy_fall", 64'(fall_cyc), 64'd522);
    check("cl_ram", 64'(ram_bad(2)), 64'd0);

    // Clean+invalidate, ack on first WB cycle: 510 x2 + 2 x3 = 1026
    fill(1);
    start_sweep(1'b1, 1'b1);
    run_sweep(0, 0, 32'h0, 1'b0, 3000);
    check("ci_wb_count", 64'(wb_addrs.size()), 64'd2);
    check("ci_wb_addr0", 64'(addr_at(0)), 64'h000A8060);
    check("ci_wb_addr1", 64'(addr_at(1)), 64'hFFFFC0E0);
    check("ci_wb_len0", 64'(len_at(0)), 64'd1);
    check("ci_wb_len1", 64'(len_at(1)), 64'd1);
    check("ci_done_cyc", 64'(done_cyc), 64'd1027);
    check("ci_ram_zero", 64'(ram_bad(3)), 64'd0);

    // start_inv and a core write to line 5 held from mid-sweep: ignored
    fill(1);
    start_sweep(1'b0, 1'b1);
    run_sweep(2, 100, 32'h0, 1'b0, 2000);
    check("mid_done_cnt", 64'(done_cnt), 64'd1);
    check("mid_done_cyc", 64'(done_cyc), 64'd521);
    check("mid_ram5", 64'(ram[9'd5]), 64'h80005);
    check("mid_ram", 64'(ram_bad(2)), 64'd0);

    // Reset during WB of line 7
    fill(1);
    start_sweep(1'b0, 1'b1);
    run_sweep(2, 0, 32'hFFFFC0E0, 1'b1, 2000);
    check("rwb_reached", 64'(stopped), 64'd1);
    nRESET = 1'b0;
    #1;
    check("rwb_drop", 64'({wb_req, busy, core_stall, tag_wr_ena, done}), 64'd0);
    @(posedge nGCLK); #1;
    check("rwb_done_cnt", 64'(done_cnt), 64'd0);
    check("rwb_ram3", 64'(ram[9'd3]), 64'h8002A);
    check("rwb_ram7", 64'(ram[9'd7]), 64'hFFFFF);
    @(negedge nGCLK); nRESET = 1'b1;
    @(posedge nGCLK); #1;
    core_rd_sel = 9'd7; core_wr_sel = 9'd7; core_wr_data = 20'h00123; core_wr_ena = 1'b1;
    @(negedge nGCLK);
    check("rwb_post_pass", 64'({busy, tag_rd_sel, tag_rd_data, tag_wr_ena, tag_wr_sel}),
          64'({1'b0, 9'd7, 20'hFFFFF, 1'b1, 9'd7}));
    @(posedge nGCLK); #1;
    core_wr_ena = 1'b0;
    check("rwb_post_wr", 64'(ram[9'd7]), 64'h00123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
